// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mem_arb_pkg;

    localparam int WORD_W         = 32;
    localparam int DEPTH_LOG2_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        RD_IF,
        RD_D
    } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of cycles in which a pending fetch was not granted.
module mem_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic limit_hit
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (if_gnt) begin
            cnt <= '0;
        end else if (if_req && (cnt != LIMIT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign limit_hit = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for the shared single-port memory.
// Optional MEM_ARB_ADDR_CHECK_EN flags misaligned/out-of-range data accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [WORD_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [WORD_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WORD_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic [WORD_W-1:0]     mem_rdata
);

    arb_state_e        state, state_n;
    logic              limit_hit;
    logic              d_bad;
    logic              we_q;
    logic              err_q;
    logic [WORD_W-1:0] if_rdata_q;
    logic [WORD_W-1:0] d_rdata_q;
    logic [WORD_W-1:0] d_rd_now;
    logic              unused_addr;

    assign unused_addr = ^{if_addr[31:DEPTH_LOG2+2], if_addr[1:0],
                           d_addr[31:DEPTH_LOG2+2], d_addr[1:0]};

`ifdef MEM_ARB_ADDR_CHECK_EN
    assign d_bad = (d_addr[1:0] != 2'b00) ||
                   (d_addr[31:DEPTH_LOG2+2] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (d_gnt) begin
            err_q <= d_bad;
        end
    end
`else
    assign d_bad = 1'b0;
    assign err_q = 1'b0;
`endif

    mem_arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .limit_hit(limit_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Outputs are forced low while reset is held so an in-flight read is dropped.
    always_comb begin
        state_n   = state;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        d_err     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (if_req && (!d_req || limit_hit)) begin
                        if_gnt   = 1'b1;
                        mem_en   = 1'b1;
                        mem_addr = if_addr[DEPTH_LOG2+1:2];
                        state_n  = RD_IF;
                    end else if (d_req) begin
                        d_gnt     = 1'b1;
                        mem_en    = !d_bad;
                        mem_we    = d_we;
                        mem_addr  = d_addr[DEPTH_LOG2+1:2];
                        mem_wdata = d_wdata;
                        if (!d_we || d_bad) begin
                            state_n = RD_D;
                        end
                    end
                end
                RD_IF: begin
                    if_rvalid = 1'b1;
                    state_n   = IDLE;
                end
                RD_D: begin
                    d_rvalid = !we_q;
                    d_err    = err_q;
                    state_n  = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign d_rd_now = err_q ? '0 : mem_rdata;
    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid ? d_rd_now : d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (d_gnt) begin
                we_q <= d_we;
            end
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= d_rd_now;
            end
        end
    end

endmodule
